// File: rtl/csr_hpm_bank.sv
// Hardware performance monitor CSR bank: mcycle, minstret and mhpmcounters with
// event selectors, inhibit/enable masks, one-cycle registered CSR response and overflow IRQ.

module csr_hpm_cnt #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wd,
  output logic [63:0] cnt
);
  // A write to either half wins over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (wr_lo) cnt <= (XLEN == 32) ? {cnt[63:32], wd[31:0]} : wd;
    else if (wr_hi) cnt <= {wd[31:0], cnt[31:0]};
    else if (inc)   cnt <= cnt + 64'd1;
  end
endmodule

module csr_hpm_bank #(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 8,
  parameter int NUM_EVT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_en,
  input  logic               we_csr,
  input  logic [11:0]        r_csr_addr,
  input  logic [XLEN-1:0]    w_csr_data,
  input  logic [1:0]         priv_lvl,
  input  logic               instr_retired,
  input  logic [NUM_EVT-1:0] events,
  output logic [XLEN-1:0]    csr_data,
  output logic               csr_hit,
  output logic               exc_en,
  output logic [3:0]         exc_code,
  output logic [XLEN-1:0]    exc_val,
  output logic               ovf_irq
);
  localparam bit          X32      = (XLEN == 32);
  localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] IMPL     = HPM_BITS[31:0] | 32'h5;
  localparam logic [8:0]  NEVT     = 9'(NUM_EVT);

  logic [4:0]  idx;
  logic [6:0]  blk;
  logic        is_mcnt_lo, is_mcnt_hi, is_ucnt_lo, is_ucnt_hi, is_evt_lo, is_evt_hi;
  logic        is_inh, is_mcen, is_scen, is_ucnt, is_hi, hit;
  logic        priv_bad, cen_bad, illegal, wr_ok;
  logic [31:0] inh_q, mcen_q, scen_q;
  logic [31:0][63:0] cnt;
  logic [31:0][7:0]  sel_q;
  logic [31:0]       of_q;
  logic [63:0] wd, full, rd64;
  logic [255:0] evt_pad;

  assign wd      = 64'(w_csr_data);
  assign evt_pad = 256'(events);
  assign idx     = r_csr_addr[4:0];
  assign blk     = r_csr_addr[11:5];

  // Index 1 (time) is never part of this bank; indices 0..2 have no mhpmevent.
  assign is_mcnt_lo = (blk == 7'h58) && (idx != 5'd1);
  assign is_mcnt_hi = X32 && (blk == 7'h5C) && (idx != 5'd1);
  assign is_ucnt_lo = (blk == 7'h60) && (idx != 5'd1);
  assign is_ucnt_hi = X32 && (blk == 7'h64) && (idx != 5'd1);
  assign is_evt_lo  = (blk == 7'h19) && (idx >= 5'd3);
  assign is_evt_hi  = X32 && (blk == 7'h39) && (idx >= 5'd3);
  assign is_inh     = (r_csr_addr == 12'h320);
  assign is_mcen    = (r_csr_addr == 12'h306);
  assign is_scen    = (r_csr_addr == 12'h106);
  assign is_ucnt    = is_ucnt_lo | is_ucnt_hi;
  assign is_hi      = is_mcnt_hi | is_ucnt_hi | is_evt_hi;
  assign hit        = is_mcnt_lo | is_mcnt_hi | is_ucnt | is_evt_lo | is_evt_hi |
                      is_inh | is_mcen | is_scen;

  assign priv_bad = r_csr_addr[9:8] > priv_lvl;
  assign cen_bad  = is_ucnt && (((priv_lvl == 2'd1) && !mcen_q[idx]) ||
                                ((priv_lvl == 2'd0) && !(mcen_q[idx] && scen_q[idx])));
  assign illegal  = hit && (priv_bad || (we_csr && is_ucnt) || cen_bad);
  assign wr_ok    = csr_en && we_csr && hit && !illegal;

  always_comb begin
    full = '0;
    if (is_mcnt_lo || is_mcnt_hi || is_ucnt) full = cnt[idx];
    else if (is_evt_lo || is_evt_hi)         full = {of_q[idx], 55'd0, sel_q[idx]};
    else if (is_inh)                         full = {32'd0, inh_q};
    else if (is_mcen)                        full = {32'd0, mcen_q};
    else if (is_scen)                        full = {32'd0, scen_q};
    rd64 = is_hi ? {32'd0, full[63:32]} : full;
  end

  for (genvar i = 0; i < 32; i++) begin : g_ctr
    if (IMPL[i]) begin : g_on
      logic sel_hit, wr_lo, wr_hi, src, inc;
      assign sel_hit = (idx == 5'(i));
      assign wr_lo   = wr_ok && is_mcnt_lo && sel_hit;
      assign wr_hi   = wr_ok && is_mcnt_hi && sel_hit;
      assign inc     = src && !inh_q[i];

      csr_hpm_cnt #(.XLEN(XLEN)) u_cnt (
        .clk(clk), .rst(rst), .inc(inc), .wr_lo(wr_lo), .wr_hi(wr_hi), .wd(wd), .cnt(cnt[i])
      );

      if (i >= 3) begin : g_evt
        logic [7:0] sel_r, sel_m1;
        logic       of_r, wrap, ev_wr_lo, ev_wr_hi;
        assign sel_m1   = sel_r - 8'd1;
        assign src      = (sel_r != 8'd0) && ({1'b0, sel_r} <= NEVT) && evt_pad[sel_m1];
        assign wrap     = inc && !wr_lo && !wr_hi && (&cnt[i]);
        assign ev_wr_lo = wr_ok && is_evt_lo && sel_hit;
        assign ev_wr_hi = wr_ok && is_evt_hi && sel_hit;
        // OF is sticky; only a software write to the half holding it can clear it.
        always_ff @(posedge clk) begin
          if (rst) begin
            sel_r <= '0;
            of_r  <= 1'b0;
          end else begin
            if (ev_wr_lo) sel_r <= wd[7:0];
            if (ev_wr_lo && !X32) of_r <= wd[63];
            else if (ev_wr_hi)    of_r <= wd[31];
            else                  of_r <= of_r | wrap;
          end
        end
        assign sel_q[i] = sel_r;
        assign of_q[i]  = of_r;
      end else begin : g_fix
        assign src      = (i == 0) ? 1'b1 : instr_retired;
        assign sel_q[i] = '0;
        assign of_q[i]  = 1'b0;
      end
    end else begin : g_off
      assign cnt[i]   = '0;
      assign sel_q[i] = '0;
      assign of_q[i]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_q  <= '0;
      mcen_q <= '0;
      scen_q <= '0;
    end else if (wr_ok) begin
      if (is_inh)  inh_q  <= wd[31:0] & IMPL;
      if (is_mcen) mcen_q <= wd[31:0] & IMPL;
      if (is_scen) scen_q <= wd[31:0] & IMPL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !csr_en) begin
      csr_data <= '0;
      csr_hit  <= 1'b0;
      exc_en   <= 1'b0;
      exc_code <= '0;
      exc_val  <= '0;
    end else begin
      csr_hit  <= hit;
      exc_en   <= illegal;
      exc_code <= illegal ? 4'd2 : 4'd0;
      exc_val  <= illegal ? {{(XLEN-12){1'b0}}, r_csr_addr} : '0;
      csr_data <= (hit && !illegal) ? rd64[XLEN-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_irq <= 1'b0;
    else     ovf_irq <= |of_q;
  end
endmodule

// File: tb/tb_csr_hpm_bank.sv
// Bench for csr_hpm_bank: directed scenarios plus randomized traffic checked
// against a behavioural CSR model; a second XLEN=32 instance covers split halves.

module tb_csr_hpm_bank;
  localparam int NUM_HPM = 8;
  localparam int NUM_EVT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1, csr_en = 1'b0, we_csr = 1'b0, instr_retired = 1'b0;
  logic [11:0] r_csr_addr = '0;
  logic [63:0] w_csr_data = '0;
  logic [1:0]  priv_lvl = 2'd3;
  logic [15:0] events = '0;
  logic [63:0] csr_data, exc_val;
  logic        csr_hit, exc_en, ovf_irq;
  logic [3:0]  exc_code;
  logic [31:0] d32, v32;
  logic        h32, e32, i32;
  logic [3:0]  c32;

  csr_hpm_bank #(.XLEN(64), .NUM_HPM(NUM_HPM), .NUM_EVT(NUM_EVT)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .we_csr(we_csr), .r_csr_addr(r_csr_addr),
    .w_csr_data(w_csr_data), .priv_lvl(priv_lvl), .instr_retired(instr_retired),
    .events(events), .csr_data(csr_data), .csr_hit(csr_hit), .exc_en(exc_en),
    .exc_code(exc_code), .exc_val(exc_val), .ovf_irq(ovf_irq)
  );

  csr_hpm_bank #(.XLEN(32), .NUM_HPM(NUM_HPM), .NUM_EVT(NUM_EVT)) dut32 (
    .clk(clk), .rst(rst), .csr_en(csr_en), .we_csr(we_csr), .r_csr_addr(r_csr_addr),
    .w_csr_data(w_csr_data[31:0]), .priv_lvl(priv_lvl), .instr_retired(instr_retired),
    .events(events), .csr_data(d32), .csr_hit(h32), .exc_en(e32),
    .exc_code(c32), .exc_val(v32), .ovf_irq(i32)
  );

  always #5 clk = ~clk;

  // behavioural model state (64-bit instance)
  logic [63:0] m_cnt [32];
  logic [7:0]  m_sel [32];
  bit          m_of  [32];
  logic [31:0] m_inh, m_mcen, m_scen;
  logic [63:0] e_data = '0, e_val = '0;
  logic        e_hit = 1'b0, e_exc = 1'b0, e_irq = 1'b0;
  logic [3:0]  e_code = '0;
  int          n_run = 0, n_fail = 0;
  logic [134:0] act_v, exp_v;

  assign act_v = {csr_hit, exc_en, exc_code, exc_val, csr_data, ovf_irq};
  assign exp_v = {e_hit, e_exc, e_code, e_val, e_data, e_irq};

  function automatic bit impl(int i);
    return i == 0 || i == 2 || (i >= 3 && i < 3 + NUM_HPM);
  endfunction

  // Drive one request cycle, compute the expected response from the model's
  // start-of-cycle state, advance the model, then wait past the edge.
  task automatic step(input bit r, input bit en, input bit we, input logic [11:0] ad,
                      input logic [63:0] wd, input logic [1:0] pv, input bit ir,
                      input logic [15:0] ev);
    int i, kind;
    bit ill, act;
    logic [31:0] mask;
    rst = r; csr_en = en; we_csr = we; r_csr_addr = ad; w_csr_data = wd;
    priv_lvl = pv; instr_retired = ir; events = ev;
    e_hit = 0; e_exc = 0; e_code = 0; e_val = 0; e_data = 0; e_irq = 0;
    if (!r) for (int k = 0; k < 32; k++) if (m_of[k]) e_irq = 1;
    i = int'(ad[4:0]);
    kind = 0;
    if (ad >= 12'hB00 && ad <= 12'hB1F && ad != 12'hB01)      kind = 1;
    else if (ad >= 12'hC00 && ad <= 12'hC1F && ad != 12'hC01) kind = 2;
    else if (ad >= 12'h323 && ad <= 12'h33F)                  kind = 3;
    else if (ad == 12'h320) kind = 4;
    else if (ad == 12'h306) kind = 5;
    else if (ad == 12'h106) kind = 6;
    ill = (int'(ad[9:8]) > int'(pv)) ||
          (kind == 2 && (we || (pv == 2'd1 && !m_mcen[i]) ||
                         (pv == 2'd0 && !(m_mcen[i] && m_scen[i]))));
    if (!r && en && kind != 0) begin
      e_hit = 1;
      if (ill) begin
        e_exc = 1; e_code = 4'd2; e_val = 64'(ad);
      end else begin
        case (kind)
          1, 2: e_data = impl(i) ? m_cnt[i] : 64'd0;
          3: e_data = impl(i) ? {m_of[i], 55'd0, m_sel[i]} : 64'd0;
          4: e_data = {32'd0, m_inh};
          5: e_data = {32'd0, m_mcen};
          default: e_data = {32'd0, m_scen};
        endcase
      end
    end
    if (r) begin
      for (int k = 0; k < 32; k++) begin m_cnt[k] = 0; m_sel[k] = 0; m_of[k] = 0; end
      m_inh = 0; m_mcen = 0; m_scen = 0;
    end else begin
      mask = 0;
      for (int k = 0; k < 32; k++) begin
        if (!impl(k)) continue;
        mask[k] = 1'b1;
        act = 0;
        if (k == 0) act = 1;
        else if (k == 2) act = ir;
        else if (m_sel[k] >= 1 && m_sel[k] <= NUM_EVT) act = ev[m_sel[k] - 1];
        if (act && !m_inh[k]) begin
          if (k >= 3 && m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) m_of[k] = 1;
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
      if (en && we && kind != 0 && !ill) begin
        case (kind)
          1: if (impl(i)) m_cnt[i] = wd;
          3: if (impl(i)) begin m_sel[i] = wd[7:0]; m_of[i] = wd[63]; end
          4: m_inh  = wd[31:0] & mask;
          5: m_mcen = wd[31:0] & mask;
          6: m_scen = wd[31:0] & mask;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 12'hB00, 64'h1234, 2'd3, 1, 16'hFFFF);
    step(1, 1, 0, 12'hB00, 64'd0, 2'd3, 1, 16'hFFFF);
    n_run++;
    if (act_v !== 135'd0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", act_v); end
  endtask

  task automatic test_mcycle();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
      n_run++;
      if ({csr_hit, exc_en, exc_code, exc_val, csr_data} !== 134'd0) begin
        n_fail++; $display("FAIL idle_zero[%0d]: got %h want 0", k, csr_data);
      end
    end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({csr_hit, exc_en, csr_data} !== {1'b1, 1'b0, 64'd5}) begin
      n_fail++; $display("FAIL mcycle_5: got hit=%b exc=%b data=%0d want 1 0 5", csr_hit, exc_en, csr_data);
    end
  endtask

  task automatic test_event_count();
    step(0, 1, 1, 12'h323, 64'd2, 2'd3, 0, 16'h0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 12'h0, 64'd0, 2'd3, 0, {14'd0, 1'b1, k[0]});
    step(0, 1, 0, 12'hB03, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'd10) begin n_fail++; $display("FAIL evt_count: got %0d want 10", csr_data); end
    n_run++;
    if (act_v !== exp_v) begin n_fail++; $display("FAIL evt_model: got %h want %h", act_v, exp_v); end
  endtask

  task automatic test_overflow();
    step(0, 1, 1, 12'hB03, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 0, 16'h2);
    step(0, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h2);
    step(0, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h2);
    n_run++;
    if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b want 0", ovf_irq); end
    step(0, 1, 0, 12'hB03, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({ovf_irq, csr_data} !== {1'b1, 64'd0}) begin
      n_fail++; $display("FAIL ovf_wrap: got irq=%b data=%h want 1 0", ovf_irq, csr_data);
    end
    step(0, 1, 0, 12'h323, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'h8000_0000_0000_0002) begin
      n_fail++; $display("FAIL ovf_flag: got %h want 8000000000000002", csr_data);
    end
    step(0, 1, 1, 12'h323, 64'd2, 2'd3, 0, 16'h0);
    step(0, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_irq); end
  endtask

  task automatic test_priv();
    step(0, 1, 1, 12'h306, 64'h4, 2'd3, 1, 16'h0);
    step(0, 1, 1, 12'h106, 64'h0, 2'd3, 1, 16'h0);
    step(0, 1, 0, 12'hC02, 64'd0, 2'd0, 1, 16'h0);
    n_run++;
    if ({csr_hit, exc_en, exc_code, exc_val, csr_data} !== {1'b1, 1'b1, 4'd2, 64'hC02, 64'd0}) begin
      n_fail++; $display("FAIL u_cen: got exc=%b code=%0d val=%h want 1 2 c02", exc_en, exc_code, exc_val);
    end
    step(0, 1, 1, 12'h106, 64'h4, 2'd3, 0, 16'h0);
    step(0, 1, 0, 12'hC02, 64'd0, 2'd0, 1, 16'h0);
    n_run++;
    if ({exc_en, act_v} !== {1'b0, exp_v}) begin
      n_fail++; $display("FAIL u_instret: got %h want %h", act_v, exp_v);
    end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd0, 0, 16'h0);
    n_run++;
    if (act_v !== exp_v || exc_val !== 64'hB00) begin
      n_fail++; $display("FAIL u_mcsr: got %h want %h", act_v, exp_v);
    end
    step(0, 1, 0, 12'hC00, 64'd0, 2'd1, 0, 16'h0);
    n_run++;
    if (act_v !== exp_v || exc_en !== 1'b1) begin
      n_fail++; $display("FAIL s_cen: got %h want %h", act_v, exp_v);
    end
    step(0, 1, 0, 12'h106, 64'd0, 2'd1, 0, 16'h0);
    n_run++;
    if (act_v !== exp_v || csr_data !== 64'h4) begin
      n_fail++; $display("FAIL s_scen: got %h want %h", act_v, exp_v);
    end
  endtask

  task automatic test_write_wins();
    step(0, 1, 1, 12'hB00, 64'd100, 2'd3, 0, 16'h0);
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'd100) begin n_fail++; $display("FAIL wr_win0: got %0d want 100", csr_data); end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'd101) begin n_fail++; $display("FAIL wr_win1: got %0d want 101", csr_data); end
    step(0, 1, 1, 12'hC00, 64'd7, 2'd3, 0, 16'h0);
    n_run++;
    if ({exc_en, exc_val} !== {1'b1, 64'hC00}) begin
      n_fail++; $display("FAIL ro_write: got exc=%b val=%h want 1 c00", exc_en, exc_val);
    end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'd103) begin n_fail++; $display("FAIL ro_nochg: got %0d want 103", csr_data); end
  endtask

  task automatic test_warl();
    step(0, 1, 1, 12'h320, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 16'h0);
    step(0, 1, 0, 12'h320, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'h7FD) begin n_fail++; $display("FAIL inh_mask: got %h want 7fd", csr_data); end
    step(0, 1, 1, 12'h320, 64'd0, 2'd3, 0, 16'h0);
    step(0, 1, 1, 12'h324, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 16'hFFFF);
    step(0, 1, 0, 12'h324, 64'd0, 2'd3, 0, 16'hFFFF);
    n_run++;
    if (csr_data !== 64'h8000_0000_0000_00FF) begin
      n_fail++; $display("FAIL evt_mask: got %h want 80000000000000ff", csr_data);
    end
    step(0, 1, 0, 12'hB04, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (csr_data !== 64'd0) begin n_fail++; $display("FAIL sel_big: got %0d want 0", csr_data); end
    step(0, 1, 1, 12'hB1F, 64'd5, 2'd3, 0, 16'h0);
    step(0, 1, 0, 12'hB1F, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({csr_hit, exc_en, csr_data} !== {1'b1, 1'b0, 64'd0}) begin
      n_fail++; $display("FAIL unimpl: got hit=%b data=%h want 1 0", csr_hit, csr_data);
    end
    step(0, 1, 0, 12'hC01, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({csr_hit, exc_en, csr_data} !== 66'd0) begin
      n_fail++; $display("FAIL time_miss: got hit=%b exc=%b want 0 0", csr_hit, exc_en);
    end
    step(0, 1, 1, 12'h324, 64'd0, 2'd3, 0, 16'h0);
  endtask

  task automatic test_random();
    logic [11:0] alist [0:19];
    logic [11:0] ad;
    logic [63:0] wd;
    logic [1:0]  pv;
    alist = '{12'hB00, 12'hB02, 12'hB03, 12'hB05, 12'hB0A, 12'hB1F, 12'hC00, 12'hC02,
              12'hC03, 12'hC06, 12'h320, 12'h323, 12'h325, 12'h32A, 12'h306, 12'h106,
              12'hB80, 12'hC01, 12'h321, 12'hF11};
    for (int k = 0; k < 400; k++) begin
      ad = ($urandom_range(0, 9) == 0) ? 12'($urandom) : alist[$urandom_range(0, 19)];
      wd = {$urandom, $urandom};
      if (ad >= 12'h323 && ad <= 12'h33F) wd = {wd[63], 55'd0, 8'($urandom_range(0, 20))};
      else if (ad[11:8] == 4'hB && $urandom_range(0, 1) == 1) wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else if (ad == 12'h320) wd = wd & 64'h0000_0000_0000_0F0A;
      case ($urandom_range(0, 2))
        0: pv = 2'd0;
        1: pv = 2'd1;
        default: pv = 2'd3;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           ad, wd, pv, 1'($urandom), 16'($urandom));
      n_run++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL rand[%0d]: got %h want %h", k, act_v, exp_v); end
    end
  endtask

  task automatic test_xlen32();
    step(1, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h0);
    step(0, 1, 1, 12'hB80, 64'd1, 2'd3, 0, 16'h0);
    n_run++;
    if (act_v !== exp_v || csr_hit !== 1'b0) begin
      n_fail++; $display("FAIL x64_hi_miss: got %h want %h", act_v, exp_v);
    end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({h32, e32, d32} !== {1'b1, 1'b0, 32'd3}) begin
      n_fail++; $display("FAIL x32_lo: got hit=%b data=%0d want 1 3", h32, d32);
    end
    step(0, 1, 0, 12'hB80, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({h32, e32, d32} !== {1'b1, 1'b0, 32'd1}) begin
      n_fail++; $display("FAIL x32_hi: got hit=%b data=%0d want 1 1", h32, d32);
    end
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if (d32 !== 32'd5) begin n_fail++; $display("FAIL x32_lo_run: got %0d want 5", d32); end
    step(1, 0, 0, 12'h0, 64'd0, 2'd3, 0, 16'h0);
    step(0, 1, 0, 12'hB00, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({h32, d32} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL x32_rst_lo: got %0d want 0", d32); end
    step(0, 1, 0, 12'hB80, 64'd0, 2'd3, 0, 16'h0);
    n_run++;
    if ({h32, d32} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL x32_rst_hi: got %0d want 0", d32); end
  endtask

  initial begin
    test_reset();
    test_mcycle();
    test_event_count();
    test_overflow();
    test_priv();
    test_write_wins();
    test_warl();
    test_random();
    test_xlen32();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_hpm_bank.md
CSR_HPM_BANK -- requirements
Module: csr_hpm_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  XLEN, 64, CSR data width (32 or 64)
  NUM_HPM, 8, implemented mhpmcounter3..(3+NUM_HPM-1), range 0..29
  NUM_EVT, 16, event input count, range 1..255
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, clock
  rst, in, 1, reset
  csr_en, in, 1, CSR access strobe; all other request inputs are valid only when this is high
  we_csr, in, 1, write request
  r_csr_addr, in, 12, CSR address
  w_csr_data, in, XLEN, write data
  priv_lvl, in, 2, privilege level: 0 = U, 1 = S, 3 = M
  instr_retired, in, 1, one instruction retired this cycle
  events, in, NUM_EVT, per-cycle event pulses
  csr_data, out, XLEN, read data
  csr_hit, out, 1, address belongs to this bank
  exc_en, out, 1, illegal-instruction exception
  exc_code, out, 4, exception code
  exc_val, out, XLEN, exception value
  ovf_irq, out, 1, counter-overflow interrupt request
REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 The bank SHALL implement these CSRs:
  - mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N
  - mcountinhibit 0x320, mhpmeventN 0x320+N
  - mcounteren 0x306, scounteren 0x106
  - cycle 0xC00, instret 0xC02, hpmcounterN 0xC00+N
  - N runs from 3 to 3+NUM_HPM-1.
REQ-005 When XLEN=32, addresses 0xB80+i and 0xC80+i SHALL access bits [63:32] of the 64-bit counter i, and the base addresses SHALL access bits [31:0].
REQ-006 When XLEN=64, the high-half addresses SHALL be non-hit.
REQ-007 Every counter SHALL be 64 bits wide.
REQ-008 Response latency SHALL be 1 cycle: csr_data, csr_hit, exc_en, exc_code and exc_val are registered from the request cycle.
REQ-009 When csr_en is low in the request cycle, all five response outputs SHALL be 0 in the following cycle.
REQ-010 Read data SHALL be the value held at the start of the request cycle (pre-increment).
REQ-011 Address handling:
  - Addresses in the counter and event ranges whose index is not implemented SHALL hit, read 0 and ignore writes (WARL zero).
  - 0xC01, 0xC81 (time) and all other addresses SHALL give csr_hit=0, csr_data=0, exc_en=0.
REQ-012 An illegal access SHALL set exc_en=1, exc_code=2 and exc_val = zero-extended r_csr_addr. An access is illegal if any of the following holds:
  - r_csr_addr[9:8] > priv_lvl;
  - a write to the 0xC00-0xC9F read-only range;
  - in S-mode, an access to user counter i with mcounteren[i]=0;
  - in U-mode, an access to user counter i with mcounteren[i]=0 or scounteren[i]=0.
REQ-013 An illegal access SHALL NOT modify any state.
REQ-014 Counting:
  - Counter i SHALL increment by exactly 1 per cycle when its source is active and mcountinhibit[i]=0.
  - Sources: mcycle every cycle; minstret on instr_retired; hpm k on events[mhpmeventk[7:0]-1] when mhpmeventk[7:0] is in 1..NUM_EVT.
  - Event select 0 or a value greater than NUM_EVT SHALL never count.
REQ-015 A legal write and an increment to the same counter in the same cycle: the write SHALL win, and the written value SHALL be visible on the next cycle with no increment applied.
REQ-016 A write to one XLEN=32 half SHALL preserve the other half and suppress the increment that cycle.
REQ-017 An hpm counter wrapping from all-ones to 0 SHALL set mhpmeventk[63] (OF) in the same edge. OF SHALL stay set until software writes it.
REQ-018 mcycle and minstret wrap silently, with no OF.
REQ-019 For XLEN=32, the OF bit SHALL sit in the high half of mhpmevent, at address 0x720+N.
REQ-020 ovf_irq SHALL be the registered OR of all OF bits; it is 1 cycle behind the OF update.
REQ-021 Writable bits:
  - mhpmevent: bits [7:0] and 63; all others read 0.
  - mcountinhibit, mcounteren, scounteren: bits 0, 2 and the implemented hpm bits; bit 1 and unimplemented bits read 0.

Reset
REQ-022 On rst=1 at a clk edge, all counters, mhpmevent, mcountinhibit, mcounteren and scounteren SHALL become 0.
REQ-023 On the same edge, csr_data, csr_hit, exc_en, exc_code, exc_val and ovf_irq SHALL become 0.
REQ-024 Reset SHALL override a simultaneous write or increment.
REQ-025 A request presented in a reset cycle SHALL produce no response.

Verification
REQ-026 Reset, then M-mode read of 0xB00 five cycles after reset release -> csr_data = 5 (pre-increment value of that cycle); csr_hit=1; exc_en=0.
REQ-027 Set mhpmevent3=2, pulse events[1] for 10 cycles with events[0] toggling, then read 0xB03 -> 10.
REQ-028 Write mhpmcounter3 = 0xFFFF_FFFF_FFFF_FFFE with event 1 held high -> after 2 increments, counter = 0, mhpmevent3[63]=1, ovf_irq=1 one cycle later.
REQ-029 U-mode read of 0xC02 with mcounteren=0x4 and scounteren=0 -> exc_en=1, exc_code=2, exc_val=0xC02, no state change. After setting scounteren=0x4, the same read returns minstret.
REQ-030 Same-cycle write of mcycle=100 while counting -> the next-cycle read returns 100 and the following cycle returns 101. Write 0xC00 in M-mode -> exc_en=1 and mcycle is unchanged.
REQ-031 XLEN=32 build: write 0xB80=1, then read 0xB00 and 0xB80 -> high half = 1, low half continues counting. Reset asserted mid-count -> all counters read 0.
